flash_map_ctrl: RTL and testbench

Parametrised successor to the single-bank flash/maprom glue for the 68000 accelerator. It decodes CPU cycles into a multi-bank flash and provides the early-boot overlay. A CPU-writable config register selects the maprom bank and enables maprom. Wait states are programmable per speed mode, and every flash cycle is gated on FLASH_BUSY_n, with a timeout.

---
 rtl/flash_map_ctrl_pkg.sv | 32 +++
 rtl/flash_map_ctrl_if.sv | 26 ++
 rtl/flash_map_ctrl_wait_timer.sv | 38 +++
 rtl/flash_map_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_flash_map_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_map_ctrl_pkg.sv
// flash_map_pkg: shared definitions for the flash/maprom controller.
//   - fsm_state_e : bus-cycle FSM states
//   - region constants used by the address decoder
//   - CLKSEL jumper codes that select the fast CPU clock
//   - cnt_width() : counter width helper that never returns 0
package flash_map_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BUSY = 2'd2,
    ACK  = 2'd3
  } fsm_state_e;

  // Region tags, compared against the top address bits.
  localparam logic [3:0] REGION_A_NIB   = 4'hA;      // A[23:20], $A00000-$AFFFFF
  localparam logic [3:0] REGION_LOW_NIB = 4'h0;      // A[23:20], $000000-$0FFFFF
  localparam logic [4:0] REGION_F8_TOP  = 5'b11111;  // A[23:19], $F80000-$FFFFFF
  localparam logic [4:0] REGION_E0_TOP  = 5'b11100;  // A[23:19], $E00000-$E7FFFF
  localparam logic [7:0] CIA_PAGE       = 8'hBF;     // A[23:16]

  // CLKSEL {JP2,JP3,JP4} codes that select the fast clock.
  localparam logic [2:0] CLKSEL_FAST_A = 3'b101;
  localparam logic [2:0] CLKSEL_FAST_B = 3'b110;

  // Width able to hold 0..max_val; at least one bit so a zero limit still
  // yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flash_map_ctrl_if.sv
// flash_map_ctrl_if: 68000 CPU bus as seen by the flash/maprom controller.
//   A[23:1], AS_CPU_n, DS_n, RW_n, D_HI : driven by the CPU (master)
//   DTACK_n                             : driven by the controller (slave)
//
// Handshake: a cycle starts when AS_CPU_n falls with A/RW_n valid. The slave
// acknowledges by pulling DTACK_n low and keeps it low until AS_CPU_n rises.
// AS_CPU_n rising at any point ends the cycle (normal end or abort), and
// DTACK_n returns high on the next clock edge.
interface flash_map_ctrl_if;
  logic [23:1] A;
  logic        AS_CPU_n;
  logic        DS_n;
  logic        RW_n;
  logic [7:0]  D_HI;
  logic        DTACK_n;

  modport master (
    output A, AS_CPU_n, DS_n, RW_n, D_HI,
    input  DTACK_n
  );

  modport slave (
    input  A, AS_CPU_n, DS_n, RW_n, D_HI,
    output DTACK_n
  );
endinterface

// File: rtl/flash_map_ctrl_wait_timer.sv
// flash_wait_timer: loadable saturating down-counter.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val (has priority over en)
//   en         : decrement by one, stopping at zero (never wraps)
//   done       : count is zero
module flash_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/flash_map_ctrl.sv
// flash_map_ctrl: multi-bank flash decode, maprom overlay and DTACK generation
// for a 68000 accelerator.
//   CLKCPU, RESET_n      : clock and synchronous active-low reset
//   bus                  : CPU bus (A, AS_CPU_n, DS_n, RW_n, D_HI in; DTACK_n out)
//   CLKSEL, CPU_SPEED_SWITCH : select fast/slow wait-state count
//   JP_MAPROM_n          : maprom jumper, sampled at reset
//   FLASH_BUSY_n         : flash ready; every flash cycle waits for it
//   FLASH_ACCESS         : combinational flash decode
//   FLASH_BANK           : flash address bits above A[18]
//   FLASH_RESET_n        : reset passthrough
//   FLASH_OE_n/WE_n      : registered flash strobes
//   TIMEOUT_ERR          : sticky flag, set when FLASH_BUSY_n never came back
//   dbg_state            : current bus FSM state
module flash_map_ctrl
  import flash_map_pkg::*;
#(
  parameter int          BANK_W       = 2,
  parameter int          WAIT_FAST    = 2,
  parameter int          WAIT_SLOW    = 0,
  parameter int          BUSY_TIMEOUT = 255,
  parameter logic [7:0]  CFG_PAGE     = 8'hE9
) (
  input  logic              CLKCPU,
  input  logic              RESET_n,
  flash_map_ctrl_if.slave   bus,
  input  logic [2:0]        CLKSEL,
  input  logic              JP_MAPROM_n,
  input  logic              CPU_SPEED_SWITCH,
  input  logic              FLASH_BUSY_n,
  output logic              FLASH_ACCESS,
  output logic [BANK_W:0]   FLASH_BANK,
  output logic              FLASH_RESET_n,
  output logic              FLASH_OE_n,
  output logic              FLASH_WE_n,
  output logic              TIMEOUT_ERR,
  output fsm_state_e        dbg_state
);

  localparam int WAIT_MAX = (WAIT_FAST > WAIT_SLOW) ? WAIT_FAST : WAIT_SLOW;
  localparam int CNT_W    = cnt_width(WAIT_MAX);
  localparam int TCNT_W   = cnt_width(BUSY_TIMEOUT);

  fsm_state_e        state_q, state_d;
  logic              dtack_n_q, dtack_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              timeout_err_q, timeout_err_d;
  logic              ovl_q, ovl_d;
  logic              maprom_en_q, maprom_en_d;
  logic              maprom_pending_q, maprom_pending_d;
  logic              ds_n_q, ds_n_d;
  logic [BANK_W-1:0] bank_sel_q, bank_sel_d;

  logic              as_active;
  logic [7:0]        page;
  logic              cfg_hit;
  logic              cfg_wr;
  logic              cia_wr;
  logic              fast_sel;
  logic [CNT_W-1:0]  wait_load;
  logic              wait_done;
  logic              tmo_done;
  logic              unused_bits;

  assign as_active = !bus.AS_CPU_n;
  assign page      = bus.A[23:16];
  assign cfg_hit   = (page == CFG_PAGE) && as_active;
  assign cia_wr    = (page == CIA_PAGE) && as_active && !bus.RW_n;
  // Config write fires once, on the cycle where DS_n is first seen low.
  assign cfg_wr    = cfg_hit && !bus.RW_n && ds_n_q && !bus.DS_n;
  assign unused_bits = ^{bus.A[18:1], bus.D_HI};

  // Address decode.
  always_comb begin
    FLASH_ACCESS = 1'b0;
    if (!maprom_en_q) begin
      FLASH_ACCESS = (bus.A[23:20] == REGION_A_NIB);
    end else begin
      FLASH_ACCESS = (ovl_q && (bus.A[23:20] == REGION_LOW_NIB))
                  || (bus.A[23:19] == REGION_F8_TOP)
                  || (as_active && (bus.A[23:19] == REGION_E0_TOP));
    end
  end

  // While mapped, the overlay forces the upper half of the 512 KB image so
  // the reset vectors at $000000 come from the ROM's $F80000 copy.
  assign FLASH_BANK = maprom_en_q ? {bank_sel_q, bus.A[19] | ovl_q}
                                  : {{BANK_W{1'b0}}, bus.A[19]};

  assign fast_sel  = !CPU_SPEED_SWITCH &&
                     ((CLKSEL == CLKSEL_FAST_A) || (CLKSEL == CLKSEL_FAST_B));
  assign wait_load = fast_sel ? CNT_W'(WAIT_FAST) : CNT_W'(WAIT_SLOW);

  // Wait-state timer: reloaded every IDLE cycle so the value in force when
  // the cycle starts is the one used; counts down through WAIT.
  flash_wait_timer #(.W(CNT_W)) u_wait_timer (
    .clk      (CLKCPU),
    .rst_n    (RESET_n),
    .load     (state_q == IDLE),
    .load_val (wait_load),
    .en       (state_q == WAIT),
    .done     (wait_done)
  );

  // Busy timeout: armed outside BUSY, counts down while waiting for the flash.
  flash_wait_timer #(.W(TCNT_W)) u_busy_timer (
    .clk      (CLKCPU),
    .rst_n    (RESET_n),
    .load     (state_q != BUSY),
    .load_val (TCNT_W'(BUSY_TIMEOUT)),
    .en       (state_q == BUSY),
    .done     (tmo_done)
  );

  // Bus FSM next state and registered outputs.
  always_comb begin
    state_d          = state_q;
    timeout_err_d    = timeout_err_q;
    ovl_d            = ovl_q;
    maprom_en_d      = maprom_en_q;
    maprom_pending_d = maprom_pending_q;
    bank_sel_d       = bank_sel_q;
    ds_n_d           = bus.DS_n;

    if (!as_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (FLASH_ACCESS || cfg_hit) state_d = WAIT;
        WAIT: if (wait_done) state_d = cfg_hit ? ACK : BUSY;
        BUSY: begin
          if (FLASH_BUSY_n) begin
            state_d = ACK;
          end else if (tmo_done) begin
            state_d       = ACK;
            timeout_err_d = 1'b1;
          end
        end
        ACK:     state_d = ACK;
        default: state_d = IDLE;
      endcase
    end

    if (cia_wr) ovl_d = 1'b0;
    if (cfg_wr) begin
      bank_sel_d       = bus.D_HI[BANK_W-1:0];
      maprom_pending_d = bus.D_HI[7];
    end

    dtack_n_d = (state_d != ACK);
    oe_n_d    = !(FLASH_ACCESS && as_active && bus.RW_n);
    we_n_d    = !(FLASH_ACCESS && as_active && !bus.RW_n && !bus.DS_n && !maprom_en_q);
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      dtack_n_q     <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      timeout_err_q <= 1'b0;
      ovl_q         <= 1'b1;
      bank_sel_q    <= '0;
      ds_n_q        <= 1'b1;
      // A maprom request written by software takes effect here.
      maprom_en_q   <= !JP_MAPROM_n || maprom_pending_q;
    end else begin
      state_q       <= state_d;
      dtack_n_q     <= dtack_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      timeout_err_q <= timeout_err_d;
      ovl_q         <= ovl_d;
      bank_sel_q    <= bank_sel_d;
      ds_n_q        <= ds_n_d;
      maprom_en_q   <= maprom_en_d;
    end
  end

  // The pending request must survive reset, so this flop has no reset term.
  always_ff @(posedge CLKCPU) begin
    maprom_pending_q <= maprom_pending_d;
  end

  assign bus.DTACK_n   = dtack_n_q;
  assign FLASH_OE_n    = oe_n_q;
  assign FLASH_WE_n    = we_n_q;
  assign TIMEOUT_ERR   = timeout_err_q;
  assign FLASH_RESET_n = RESET_n;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_flash_map_ctrl.sv
// Testbench for flash_map_ctrl: directed steps plus randomized bus cycles
// checked against an address-range model of the decode and cycle timing.
module tb_flash_map_ctrl;
  import flash_map_pkg::*;

  localparam int TMO = 15;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] clksel;
  logic       jp_n;
  logic       speed_sw;
  logic       busy_n;
  logic       acc;
  logic [2:0] bank;
  logic       frst_n;
  logic       oe_n;
  logic       we_n;
  logic       err;
  fsm_state_e dbg;

  flash_map_ctrl_if bus();

  flash_map_ctrl #(
    .BANK_W(2), .WAIT_FAST(2), .WAIT_SLOW(0), .BUSY_TIMEOUT(TMO), .CFG_PAGE(8'hE9)
  ) dut (
    .CLKCPU           (clk),
    .RESET_n          (rst_n),
    .bus              (bus),
    .CLKSEL           (clksel),
    .JP_MAPROM_n      (jp_n),
    .CPU_SPEED_SWITCH (speed_sw),
    .FLASH_BUSY_n     (busy_n),
    .FLASH_ACCESS     (acc),
    .FLASH_BANK       (bank),
    .FLASH_RESET_n    (frst_n),
    .FLASH_OE_n       (oe_n),
    .FLASH_WE_n       (we_n),
    .TIMEOUT_ERR      (err),
    .dbg_state        (dbg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_maprom, m_ovl, m_pending, m_err;
  bit [1:0] m_bank;

  // Results of the last cycle, for directed checks
  int         last_lat;
  logic       last_acc;
  logic [2:0] last_bank;
  bit         last_we_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_access(input logic [23:0] a);
    if (!m_maprom) return (a >= 24'hA00000) && (a <= 24'hAFFFFF);
    return (m_ovl && (a <= 24'h0FFFFF)) || (a >= 24'hF80000) ||
           ((a >= 24'hE00000) && (a <= 24'hE7FFFF));
  endfunction

  function automatic logic [2:0] model_bank(input logic [23:0] a);
    if (m_maprom) return {m_bank, a[19] | m_ovl};
    return {2'b00, a[19]};
  endfunction

  function automatic int model_wait();
    return (!speed_sw && (clksel == 3'd5 || clksel == 3'd6)) ? 2 : 0;
  endfunction

  // Edges from AS falling to DTACK low; -1 when the cycle is not ours.
  function automatic int model_lat(input logic [23:0] a);
    if (a[23:16] == 8'hE9) return model_wait() + 2;
    if (!model_access(a)) return -1;
    if (busy_n) return model_wait() + 3;
    return model_wait() + 3 + TMO;
  endfunction

  task automatic do_reset();
    bus.AS_CPU_n = 1'b1;
    bus.DS_n     = 1'b1;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dtack", bus.DTACK_n, 1'b1);
    chk("rst_oe", oe_n, 1'b1);
    chk("rst_we", we_n, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_state", dbg, IDLE);
    chk("rst_flash_reset", frst_n, 1'b0);
    rst_n     = 1'b1;
    m_maprom  = !jp_n || m_pending;
    m_ovl     = 1'b1;
    m_bank    = 2'b00;
    m_err     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_flash_reset_rel", frst_n, 1'b1);
  endtask

  // One full CPU cycle; checks decode, bank, strobes, latency and error flag.
  task automatic run_cycle(input logic [23:0] a, input bit rd, input logic [7:0] data,
                           input string tag);
    int  lat;
    int  exp_lat;
    bit  oe_low, we_low;
    bit  exp_acc;
    logic [2:0] exp_bank;
    exp_acc  = model_access(a);
    exp_bank = model_bank(a);
    exp_lat  = model_lat(a);
    bus.A        = a[23:1];
    bus.RW_n     = rd;
    bus.D_HI     = data;
    bus.AS_CPU_n = 1'b0;
    bus.DS_n     = rd ? 1'b0 : 1'b1;
    #1;
    last_acc  = acc;
    last_bank = bank;
    chk({tag, "_access"}, acc, exp_acc);
    if (exp_acc) chk({tag, "_bank"}, bank, exp_bank);
    lat = -1; oe_low = 0; we_low = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1;
      if (!oe_n) oe_low = 1;
      if (!we_n) we_low = 1;
      if (!rd && n == 1) bus.DS_n = 1'b0;
      if (bus.DTACK_n === 1'b0) begin
        lat = n;
        break;
      end
    end
    last_lat    = lat;
    last_we_low = we_low;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_oe"}, oe_low, exp_acc && rd);
    chk({tag, "_we"}, we_low, exp_acc && !rd && !m_maprom);
    if (!rd && a[23:16] == 8'hBF) m_ovl = 1'b0;
    if (!rd && a[23:16] == 8'hE9) begin
      m_bank    = data[1:0];
      m_pending = data[7];
    end
    if (exp_acc && !busy_n) m_err = 1'b1;
    bus.AS_CPU_n = 1'b1;
    bus.DS_n     = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_dtack_release"}, bus.DTACK_n, 1'b1);
    chk({tag, "_idle"}, dbg, IDLE);
    chk({tag, "_err"}, err, m_err);
  endtask

  task automatic random_cycles(input int count);
    logic [23:0] a;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 6))
        0:       a = 24'hA00000 + 24'($urandom_range(0, 20'hFFFFF));
        1:       a = 24'($urandom_range(0, 20'hFFFFF));
        2:       a = 24'hF80000 + 24'($urandom_range(0, 19'h7FFFF));
        3:       a = 24'hE00000 + 24'($urandom_range(0, 19'h7FFFF));
        4:       a = 24'hBF0000 + 24'($urandom_range(0, 16'hFFFF));
        5:       a = 24'hE90000 + 24'($urandom_range(0, 16'hFFFF));
        default: a = 24'h200000 + 24'($urandom_range(0, 21'h1FFFFF));
      endcase
      a[0]     = 1'b0;
      clksel   = 3'($urandom_range(0, 7));
      speed_sw = 1'($urandom_range(0, 1));
      busy_n   = 1'b1;
      // Keep the maprom request bit clear so later resets stay predictable.
      run_cycle(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), "rand");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.A = '0; bus.AS_CPU_n = 1'b1; bus.DS_n = 1'b1; bus.RW_n = 1'b1; bus.D_HI = '0;
    rst_n = 1'b0; clksel = 3'b000; speed_sw = 1'b1; busy_n = 1'b1; jp_n = 1'b1;
    m_pending = 1'b0;
    @(posedge clk);
    #1;

    // Maprom off, slow mode, flash read
    do_reset();
    run_cycle(24'hA00010, 1'b1, 8'h00, "basic_read");
    chk("basic_lat3", last_lat, 3);
    chk("basic_bank0", last_bank, 3'b000);
    run_cycle(24'hA00020, 1'b0, 8'h55, "basic_write");
    chk("basic_write_we", last_we_low, 1'b1);
    random_cycles(40);

    // Maprom on via jumper: overlay until the first CIA write
    jp_n = 1'b0; clksel = 3'b000; speed_sw = 1'b1;
    do_reset();
    run_cycle(24'h000100, 1'b1, 8'h00, "ovl_read");
    chk("ovl_acc", last_acc, 1'b1);
    chk("ovl_bank0", last_bank[0], 1'b1);
    run_cycle(24'hBFE001 & 24'hFFFFFE, 1'b0, 8'h03, "cia_write");
    run_cycle(24'h000100, 1'b1, 8'h00, "post_ovl_read");
    chk("post_ovl_acc", last_acc, 1'b0);

    // Fast mode wait states
    clksel = 3'b101; speed_sw = 1'b0;
    run_cycle(24'hF80000, 1'b1, 8'h00, "fast_read");
    chk("fast_lat5", last_lat, 5);
    clksel = 3'b000; speed_sw = 1'b1;

    // Bank select and mapped write blocking
    run_cycle(24'hE90000, 1'b0, 8'h02, "cfg_write");
    run_cycle(24'hF80000, 1'b1, 8'h00, "bank_read");
    chk("bank_sel2", last_bank, 3'b101);
    run_cycle(24'hA00000, 1'b0, 8'h11, "mapped_a_write");
    chk("mapped_a_we", last_we_low, 1'b0);
    run_cycle(24'hF80000, 1'b0, 8'h11, "mapped_f8_write");
    chk("mapped_f8_we", last_we_low, 1'b0);
    random_cycles(60);

    // Busy timeout
    clksel = 3'b000; speed_sw = 1'b1; busy_n = 1'b0;
    run_cycle(24'hF80010, 1'b1, 8'h00, "timeout");
    chk("timeout_lat", last_lat, 3 + TMO);
    chk("timeout_flag", err, 1'b1);
    busy_n = 1'b1;
    run_cycle(24'hF80020, 1'b1, 8'h00, "after_timeout");
    chk("timeout_sticky", err, 1'b1);

    // Abort during WAIT
    clksel = 3'b110; speed_sw = 1'b0;
    bus.A = 24'hF80000 >> 1; bus.RW_n = 1'b1; bus.AS_CPU_n = 1'b0; bus.DS_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wait", dbg, WAIT);
    bus.AS_CPU_n = 1'b1; bus.DS_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", dbg, IDLE);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("abort_no_dtack", bus.DTACK_n, 1'b1);
    end

    // Reset during BUSY
    clksel = 3'b000; speed_sw = 1'b1; busy_n = 1'b0;
    bus.A = 24'hF80000 >> 1; bus.RW_n = 1'b1; bus.AS_CPU_n = 1'b0; bus.DS_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_busy", dbg, BUSY);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_abort_idle", dbg, IDLE);
    chk("reset_abort_dtack", bus.DTACK_n, 1'b1);
    chk("reset_clears_err", err, 1'b0);
    busy_n = 1'b1;
    do_reset();

    // Software maprom request takes effect at the next reset
    jp_n = 1'b1;
    do_reset();
    run_cycle(24'hF80000, 1'b1, 8'h00, "jp_off_read");
    chk("jp_off_acc", last_acc, 1'b0);
    run_cycle(24'hE90000, 1'b0, 8'h81, "cfg_pending");
    do_reset();
    run_cycle(24'hF80000, 1'b1, 8'h00, "pending_read");
    chk("pending_acc", last_acc, 1'b1);
    chk("pending_bank", last_bank, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
